// File: rtl/sram_arb_pkg.sv
// Shared definitions for the two-port SRAM arbiter: last-winner state
// encoding and the port IDs stored in the pending-read owner bit.
package sram_arb_pkg;

  typedef enum logic {
    LAST_A = 1'b0,
    LAST_B = 1'b1
  } last_e;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a single requester always wins, and under
// contention the port that did not win last time is granted.
module rr_arb2
  import sram_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic a_valid,
  input  logic b_valid,
  output logic a_grant,
  output logic b_grant
);

  last_e state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LAST_B;
    end else begin
      state_q <= state_d;
    end
  end

  // Grants are forced low while reset is asserted, whatever the inputs do.
  always_comb begin
    a_grant = 1'b0;
    b_grant = 1'b0;
    state_d = state_q;
    if (rst_n) begin
      if (a_valid && b_valid) begin
        a_grant = (state_q == LAST_B);
        b_grant = (state_q == LAST_A);
      end else begin
        a_grant = a_valid;
        b_grant = b_valid;
      end
    end
    if (a_grant) begin
      state_d = LAST_A;
    end else if (b_grant) begin
      state_d = LAST_B;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates two request ports onto one SRAM with 1-cycle registered reads
// and routes each read response back to the port that issued it.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     a_req_valid,
  input  logic                     a_req_write,
  input  logic [ADDRESS_WIDTH-1:0] a_req_addr,
  input  logic [DATA_WIDTH-1:0]    a_req_wdata,
  output logic                     a_req_ready,
  output logic                     a_rsp_valid,
  output logic [DATA_WIDTH-1:0]    a_rsp_data,
  input  logic                     b_req_valid,
  input  logic                     b_req_write,
  input  logic [ADDRESS_WIDTH-1:0] b_req_addr,
  input  logic [DATA_WIDTH-1:0]    b_req_wdata,
  output logic                     b_req_ready,
  output logic                     b_rsp_valid,
  output logic [DATA_WIDTH-1:0]    b_rsp_data,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic                     mem_write,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
);

  logic a_grant, b_grant;
  logic pend_valid_q, pend_valid_d;
  logic pend_owner_q, pend_owner_d;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_valid (a_req_valid),
    .b_valid (b_req_valid),
    .a_grant (a_grant),
    .b_grant (b_grant)
  );

  assign a_req_ready = a_grant;
  assign b_req_ready = b_grant;

  always_comb begin
    mem_write    = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    pend_valid_d = 1'b0;
    pend_owner_d = pend_owner_q;
    if (a_grant) begin
      mem_write    = a_req_write;
      mem_addr     = a_req_addr;
      mem_wdata    = a_req_wdata;
      pend_valid_d = !a_req_write;
      pend_owner_d = PORT_A;
    end else if (b_grant) begin
      mem_write    = b_req_write;
      mem_addr     = b_req_addr;
      mem_wdata    = b_req_wdata;
      pend_valid_d = !b_req_write;
      pend_owner_d = PORT_B;
    end
  end

  // Async clear drops any read caught by reset, so it never answers later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid_q <= 1'b0;
      pend_owner_q <= PORT_A;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_owner_q <= pend_owner_d;
    end
  end

  always_comb begin
    a_rsp_valid = pend_valid_q && (pend_owner_q == PORT_A);
    b_rsp_valid = pend_valid_q && (pend_owner_q == PORT_B);
    a_rsp_data  = a_rsp_valid ? mem_rdata : '0;
    b_rsp_data  = b_rsp_valid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed scoreboard bench for sram_arbiter with a behavioural 1-cycle
// registered SRAM; initial SRAM contents are addr ^ 0x3C.
module tb_sram_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       aValid = 1'b0, aWrite = 1'b0, bValid = 1'b0, bWrite = 1'b0;
  logic [7:0] aAddr = '0, aWdata = '0, bAddr = '0, bWdata = '0;
  logic       a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid;
  logic [7:0] a_rsp_data, b_rsp_data;
  logic [7:0] mem_addr, mem_wdata;
  logic [7:0] mem_rdata = '0;
  logic       mem_write;

  int total = 0;
  int bad = 0;
  int cycleCnt = 0;

  typedef struct {
    logic       port;
    logic [7:0] data;
    int         cyc;
  } rsp_t;
  rsp_t expQ[$];

  logic [7:0] sram [256];
  bit         loadDone;

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  always @(posedge clk) begin
    if (!loadDone) begin
      for (int i = 0; i < 256; i++) sram[i] <= 8'(i) ^ 8'h3C;
      loadDone <= 1'b1;
    end else if (mem_write) begin
      sram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= sram[mem_addr];
  end

  sram_arbiter #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a_req_valid (aValid),
    .a_req_write (aWrite),
    .a_req_addr  (aAddr),
    .a_req_wdata (aWdata),
    .a_req_ready (a_req_ready),
    .a_rsp_valid (a_rsp_valid),
    .a_rsp_data  (a_rsp_data),
    .b_req_valid (bValid),
    .b_req_write (bWrite),
    .b_req_addr  (bAddr),
    .b_req_wdata (bWdata),
    .b_req_ready (b_req_ready),
    .b_rsp_valid (b_rsp_valid),
    .b_rsp_data  (b_rsp_data),
    .mem_addr    (mem_addr),
    .mem_write   (mem_write),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One request cycle: drive at negedge, check grant and SRAM-side outputs 1ns later.
  task automatic applyStimulus(
    input string tag,
    input logic aV, input logic aW, input logic [7:0] aA, input logic [7:0] aD,
    input logic bV, input logic bW, input logic [7:0] bA, input logic [7:0] bD,
    input logic eA, input logic eB, input logic eW, input logic [7:0] eAddr, input logic [7:0] eWd,
    input bit eRsp, input logic [7:0] eData);
    @(negedge clk);
    rst_n  = 1'b1;
    aValid = aV; aWrite = aW; aAddr = aA; aWdata = aD;
    bValid = bV; bWrite = bW; bAddr = bA; bWdata = bD;
    if (eRsp) expQ.push_back('{eB, eData, cycleCnt + 1});
    #1;
    checkOutput({tag, "_a_ready"}, 32'(a_req_ready), 32'(eA));
    checkOutput({tag, "_b_ready"}, 32'(b_req_ready), 32'(eB));
    checkOutput({tag, "_mem_write"}, 32'(mem_write), 32'(eW));
    checkOutput({tag, "_mem_addr"}, 32'(mem_addr), 32'(eAddr));
    checkOutput({tag, "_mem_wdata"}, 32'(mem_wdata), 32'(eWd));
  endtask

  task automatic idleCycle(input string tag);
    applyStimulus(tag, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00,
                  0, 0, 0, 8'h00, 8'h00, 0, 8'h00);
  endtask

  // Reset with both ports requesting writes; everything must stay quiet.
  task automatic doReset(input bit atEdge);
    if (atEdge) @(posedge clk);
    else @(negedge clk);
    rst_n  = 1'b0;
    aValid = 1'b1; aWrite = 1'b1; aAddr = 8'hFF; aWdata = 8'hEE;
    bValid = 1'b1; bWrite = 1'b1; bAddr = 8'h77; bWdata = 8'h66;
    repeat (2) begin
      @(negedge clk);
      #1;
      checkOutput("rst_ready", {30'd0, a_req_ready, b_req_ready}, 32'd0);
      checkOutput("rst_rsp_valid", {30'd0, a_rsp_valid, b_rsp_valid}, 32'd0);
      checkOutput("rst_rsp_data", {16'd0, a_rsp_data, b_rsp_data}, 32'd0);
      checkOutput("rst_mem", {15'd0, mem_write, mem_addr, mem_wdata}, 32'd0);
    end
  endtask

  // Monitor: pops the scoreboard whenever a response is presented.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (a_rsp_valid && b_rsp_valid) begin
        checkOutput("rsp_both_valid", 32'd1, 32'd0);
      end else if (a_rsp_valid || b_rsp_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("rsp_unexpected", {30'd0, a_rsp_valid, b_rsp_valid}, 32'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("rsp_port", 32'(b_rsp_valid), 32'(e.port));
          checkOutput("rsp_data", 32'(b_rsp_valid ? b_rsp_data : a_rsp_data), 32'(e.data));
          checkOutput("rsp_other_data", 32'(b_rsp_valid ? a_rsp_data : b_rsp_data), 32'd0);
          checkOutput("rsp_cycle", 32'(cycleCnt), 32'(e.cyc));
        end
      end else begin
        checkOutput("rsp_idle_data", {16'd0, a_rsp_data, b_rsp_data}, 32'd0);
      end
    end
  end

  initial begin
    $display("[TB] start");

    // Write then read back through A; idle; tie after A won goes to B.
    doReset(0);
    applyStimulus("t1_wr", 1, 1, 8'h10, 8'h5A, 0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h10, 8'h5A, 0, 8'h00);
    applyStimulus("t1_rd", 1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h10, 8'h00, 1, 8'h5A);
    idleCycle("t1_idle");
    applyStimulus("t1_tie", 1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00, 0, 1, 0, 8'h02, 8'h00, 1, 8'h3E);
    applyStimulus("t1_aonly", 1, 0, 8'h01, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h01, 8'h00, 1, 8'h3D);
    idleCycle("t1_idle2");

    // Sustained contention: strict alternation, back-to-back responses.
    doReset(0);
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0)
        applyStimulus("t2_alt_a", 1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00, 1, 0, 0, 8'h01, 8'h00, 1, 8'h3D);
      else
        applyStimulus("t2_alt_b", 1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00, 0, 1, 0, 8'h02, 8'h00, 1, 8'h3E);
    end
    idleCycle("t2_idle");

    // B alone keeps the state at LAST_B, so the following tie goes to A.
    doReset(0);
    for (int i = 0; i < 3; i++)
      applyStimulus("t3_bonly", 0, 0, 8'h00, 8'h00, 1, 0, 8'h02, 8'h00, 0, 1, 0, 8'h02, 8'h00, 1, 8'h3E);
    applyStimulus("t3_tie", 1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00, 1, 0, 0, 8'h01, 8'h00, 1, 8'h3D);
    applyStimulus("t3_bleft", 0, 0, 8'h00, 8'h00, 1, 0, 8'h02, 8'h00, 0, 1, 0, 8'h02, 8'h00, 1, 8'h3E);
    idleCycle("t3_idle");

    // Read/write race on 0x20: A first sees old data, B first makes A see 0xC3.
    doReset(0);
    applyStimulus("t4_rd_first", 1, 0, 8'h20, 8'h00, 1, 1, 8'h20, 8'hC3, 1, 0, 0, 8'h20, 8'h00, 1, 8'h1C);
    applyStimulus("t4_wr_second", 0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'hC3, 0, 1, 1, 8'h20, 8'hC3, 0, 8'h00);
    applyStimulus("t4_restore", 1, 1, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h20, 8'h00, 0, 8'h00);
    applyStimulus("t4_wr_first", 1, 0, 8'h20, 8'h00, 1, 1, 8'h20, 8'hC3, 0, 1, 1, 8'h20, 8'hC3, 0, 8'h00);
    applyStimulus("t4_rd_second", 1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h20, 8'h00, 1, 8'hC3);
    idleCycle("t4_idle");

    // Reset lands on the edge of a granted A read: no response may follow.
    doReset(0);
    applyStimulus("t5_lost_rd", 1, 0, 8'h01, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h01, 8'h00, 0, 8'h00);
    doReset(1);
    applyStimulus("t5_tie", 1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00, 1, 0, 0, 8'h01, 8'h00, 1, 8'h3D);
    applyStimulus("t5_bleft", 0, 0, 8'h00, 8'h00, 1, 0, 8'h02, 8'h00, 0, 1, 0, 8'h02, 8'h00, 1, 8'h3E);
    idleCycle("t5_idle");
    idleCycle("t5_idle2");

    repeat (3) @(negedge clk);
    #3;
    checkOutput("queue_drain", 32'(expQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
